lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter ADDR_W, 32, address width.
REQ-002 SHALL have parameter DATA_W, 32, data width; only 32 is supported.
REQ-003 SHALL have port clk  in  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports req_valid in 1 and req_ready out 1: EXU request handshake.
REQ-006 SHALL have ports req_wen in 1 (store), req_ren in 1 (load), req_op in 3 (funct3: 0 b, 1 h, 2 w, 4 bu, 5 hu), req_addr in 32, req_wdata in 32.
REQ-007 SHALL have ports resp_valid out 1, resp_ready in 1, resp_rdata out 32 (extended load data, 0 for stores), resp_err out 1 (misaligned access or bus error).
REQ-008 SHALL have ports awvalid out 1, awready in 1, awaddr out 32, wvalid out 1, wready in 1, wdata out 32, wstrb out 8 (bits 7:4 always 0), bvalid in 1, bready out 1, bresp in 2.
REQ-009 SHALL have ports arvalid out 1, arready in 1, araddr out 32, rvalid in 1, rready out 1, rresp in 2, rdata in 32 (raw aligned word).

Function
REQ-010 SHALL use states IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
REQ-011 SHALL assert req_ready only in IDLE; request accepted on req_valid && req_ready; address, op, data and kind registered at acceptance.
REQ-012 A request with neither req_wen nor req_ren SHALL go to RESP with rdata 0, err 0, and issue no bus transaction.
REQ-013 Misalignment (h with addr[0]=1; w with addr[1:0]!=0) SHALL go to RESP with err 1 and issue no bus transaction.
REQ-014 Load: RD_ADDR asserts arvalid with araddr = {addr[31:2],2'b00}; on arready, arvalid deasserts next cycle and state goes to RD_DATA.
REQ-015 RD_DATA SHALL hold rready=1; on rvalid, capture rdata, select lane by addr[1:0], then sign- or zero-extend per op; err = (rresp!=0); go to RESP.
REQ-016 Store: WR_REQ asserts awvalid and wvalid together in the first cycle; each drops independently the cycle after its own handshake; when both are done, go to WR_RESP.
REQ-017 Store data SHALL be replicated into lanes (b: 4x byte, h: 2x half, w: word); wstrb = 0x1<<a (b), 0x3<<a (h), 0xF (w), where a=addr[1:0].
REQ-018 awaddr SHALL be the word-aligned address; awvalid/wvalid SHALL NOT depend on awready/wready.
REQ-019 WR_RESP SHALL hold bready=1; on bvalid, err = (bresp!=0); go to RESP.
REQ-020 RESP SHALL hold resp_valid=1 with stable rdata/err until resp_ready; then return to IDLE; back-to-back requests cost at least one IDLE cycle.
REQ-021 Handshakes arriving in the same cycle as valid assertion (zero-wait slave) SHALL complete in that cycle.
REQ-022 Bus outputs SHALL be registered; arvalid, awvalid, wvalid, bready and rready SHALL be 0 outside their states.
REQ-023 Slave latency SHALL be unbounded; there is no timeout.

Reset
REQ-024 On rst, state SHALL be IDLE and all valid/ready outputs 0 except req_ready=1 on the first cycle after reset.
REQ-025 On rst, resp_rdata, resp_err, awaddr, araddr, wdata and wstrb SHALL be 0.
REQ-026 Reset mid-transaction SHALL abandon the transaction without completing a handshake; a pending slave beat is not waited for.

Structure
REQ-027 Package lsu_pkg SHALL hold the state enum, funct3 op constants (LB, LH, LW, LBU, LHU), and the resp OKAY=2'b00 constant.
REQ-028 A combinational sub-module lsu_align SHALL perform lane select, extension, replication and wstrb generation; the FSM stays in lsu.

Verification
REQ-029 LB addr 0x80000003, slave rdata 0x80FF_1234 after 5 cycles -> araddr 0x80000000, resp_rdata 0xFFFFFF80, err 0.
REQ-030 LHU addr 0x80000002, rdata 0xBEEF_0000 -> resp_rdata 0x0000BEEF.
REQ-031 SB addr 0x80000001, wdata 0x000000AB, awready a cycle before wready -> wdata 0xABABABAB, wstrb 0x02, one AW and one W handshake, resp after bvalid.
REQ-032 LW addr 0x80000002 -> no arvalid, resp_err 1 in RESP.
REQ-033 SW with bresp=2'b10 and resp_ready held low for 3 cycles -> resp_valid stable 4 cycles, err 1, then IDLE.
REQ-034 Reset asserted in RD_DATA before rvalid -> IDLE next cycle, rready 0, no resp_valid.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, funct3 access sizes,
// bus response codes and the alignment rule used at request acceptance.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        RESP    = 3'd5
    } state_e;

    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;

    localparam logic [1:0] OKAY = 2'b00;

    // op[1:0] encodes the access size for both signed and unsigned variants
    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
        case (op[1:0])
            2'd1:    return addr_lo[0];
            2'd2:    return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling: load lane select plus sign/zero extension, and
// store data replication with byte-strobe generation.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata_raw,
    input  logic [31:0] wdata_in,
    output logic [31:0] load_data,
    output logic [31:0] store_data,
    output logic [7:0]  store_strb
);

    logic [31:0] shifted;

    always_comb begin
        shifted    = rdata_raw >> {addr_lo, 3'b000};
        load_data  = rdata_raw;
        store_data = wdata_in;
        store_strb = 8'h0F;
        case (op[1:0])
            2'd0: begin
                load_data  = op[2] ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
                store_data = {4{wdata_in[7:0]}};
                store_strb = 8'h01 << addr_lo;
            end
            2'd1: begin
                load_data  = op[2] ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
                store_data = {2{wdata_in[15:0]}};
                store_strb = 8'h03 << addr_lo;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one EXU request at a time and runs it as a single
// AXI-lite style read or write transaction, returning extended data or an error.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic              req_ren,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,

    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,

    output logic              awvalid,
    input  logic              awready,
    output logic [ADDR_W-1:0] awaddr,
    output logic              wvalid,
    input  logic              wready,
    output logic [DATA_W-1:0] wdata,
    output logic [7:0]        wstrb,
    input  logic              bvalid,
    output logic              bready,
    input  logic [1:0]        bresp,

    output logic              arvalid,
    input  logic              arready,
    output logic [ADDR_W-1:0] araddr,
    input  logic              rvalid,
    output logic              rready,
    input  logic [1:0]        rresp,
    input  logic [DATA_W-1:0] rdata
);

    state_e      state;
    logic [2:0]  op_q;
    logic [1:0]  addr_lo_q;

    logic [2:0]  align_op;
    logic [1:0]  align_lo;
    logic [31:0] load_data;
    logic [31:0] store_data;
    logic [7:0]  store_strb;

    // Store lanes are needed at acceptance, load lanes after the request is registered
    assign align_op = (state == IDLE) ? req_op : op_q;
    assign align_lo = (state == IDLE) ? req_addr[1:0] : addr_lo_q;

    lsu_align u_align (
        .op         (align_op),
        .addr_lo    (align_lo),
        .rdata_raw  (rdata),
        .wdata_in   (req_wdata),
        .load_data  (load_data),
        .store_data (store_data),
        .store_strb (store_strb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op_q       <= '0;
            addr_lo_q  <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            arvalid    <= 1'b0;
            araddr     <= '0;
            rready     <= 1'b0;
            awvalid    <= 1'b0;
            awaddr     <= '0;
            wvalid     <= 1'b0;
            wdata      <= '0;
            wstrb      <= '0;
            bready     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        op_q      <= req_op;
                        addr_lo_q <= req_addr[1:0];
                        if (!req_wen && !req_ren) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= '0;
                            resp_err   <= 1'b0;
                        end else if (misaligned(req_op, req_addr[1:0])) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= '0;
                            resp_err   <= 1'b1;
                        end else if (req_wen) begin
                            state   <= WR_REQ;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            awaddr  <= {req_addr[ADDR_W-1:2], 2'b00};
                            wdata   <= store_data;
                            wstrb   <= store_strb;
                        end else begin
                            state   <= RD_ADDR;
                            arvalid <= 1'b1;
                            araddr  <= {req_addr[ADDR_W-1:2], 2'b00};
                        end
                    end
                end
                RD_ADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (rvalid) begin
                        rready     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= load_data;
                        resp_err   <= (rresp != OKAY);
                        state      <= RESP;
                    end
                end
                WR_REQ: begin
                    if (awready) awvalid <= 1'b0;
                    if (wready)  wvalid  <= 1'b0;
                    // A channel is finished once its valid is low or completes this cycle
                    if ((!awvalid || awready) && (!wvalid || wready)) begin
                        bready <= 1'b1;
                        state  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (bvalid) begin
                        bready     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                        resp_err   <= (bresp != OKAY);
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a small bus slave, a spec-level behavioural model and
// a per-cycle compare process, plus literal expectations for the listed cases.
module tb_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen, req_ren;
    logic [2:0]  req_op;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] awaddr, wdata;
    logic [7:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] araddr, rdata;

    lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_ren(req_ren),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rresp(rresp), .rdata(rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout_fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] m_load(input logic [2:0] op, input int unsigned a, input logic [31:0] w);
        int unsigned b[4];
        int unsigned v;
        for (int i = 0; i < 4; i++) b[i] = (w >> (8 * i)) & 32'hFF;
        case (op)
            3'd0: begin v = b[a]; if (v >= 128) v = v + 32'hFFFFFF00; end
            3'd4: v = b[a];
            3'd1: begin v = b[a] + 256 * b[a+1]; if (v >= 32768) v = v + 32'hFFFF0000; end
            3'd5: v = b[a] + 256 * b[a+1];
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] op, input logic [31:0] d);
        case (op)
            3'd0:    return (d & 32'hFF) * 32'h01010101;
            3'd1:    return (d & 32'hFFFF) * 32'h00010001;
            default: return d;
        endcase
    endfunction

    function automatic logic [7:0] m_wstrb(input logic [2:0] op, input int unsigned a);
        case (op)
            3'd0:    return 8'(1 << a);
            3'd1:    return 8'(3 << a);
            default: return 8'h0F;
        endcase
    endfunction

    function automatic bit m_mis(input logic [2:0] op, input int unsigned a);
        if (op == 3'd1 || op == 3'd5) return (a % 2) != 0;
        if (op == 3'd2) return a != 0;
        return 1'b0;
    endfunction

    bit          txn_active = 1'b0;
    int          exp_bus = 0;   // 0 none, 1 read, 2 write
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic [7:0]  exp_wstrb;
    logic        exp_err;

    // ---------------- monitor ----------------
    int          ar_hs = 0, aw_hs = 0, w_hs = 0, r_hs = 0, b_hs = 0;
    logic [31:0] last_araddr = '0, last_wdata = '0, last_rdata = '0;
    logic [7:0]  last_wstrb = '0;
    logic        last_err = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            if (arvalid && arready) begin ar_hs <= ar_hs + 1; last_araddr <= araddr; end
            if (awvalid && awready) aw_hs <= aw_hs + 1;
            if (wvalid && wready) begin w_hs <= w_hs + 1; last_wdata <= wdata; last_wstrb <= wstrb; end
            if (rvalid && rready) r_hs <= r_hs + 1;
            if (bvalid && bready) b_hs <= b_hs + 1;
            if (resp_valid && resp_ready) begin last_rdata <= resp_rdata; last_err <= resp_err; end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (!txn_active) begin
                chk("idle_quiet", {26'b0, arvalid, awvalid, wvalid, rready, bready, resp_valid}, 32'h0);
            end else begin
                chk("stray_ar", {31'b0, arvalid && exp_bus != 1}, 32'h0);
                chk("stray_aw_w", {31'b0, (awvalid || wvalid) && exp_bus != 2}, 32'h0);
                if (arvalid) chk("araddr", araddr, exp_addr);
                if (awvalid) chk("awaddr", awaddr, exp_addr);
                if (wvalid) begin
                    chk("wdata", wdata, exp_wdata);
                    chk("wstrb", {24'b0, wstrb}, {24'b0, exp_wstrb});
                end
                if (resp_valid) begin
                    chk("resp_rdata", resp_rdata, exp_rdata);
                    chk("resp_err", {31'b0, resp_err}, {31'b0, exp_err});
                end
            end
        end
    end

    // ---------------- slave ----------------
    function automatic logic sig(input int ch);
        case (ch)
            0: return arvalid;
            1: return awvalid;
            2: return wvalid;
            3: return rready;
            default: return bready;
        endcase
    endfunction

    task automatic set_ready(input int ch, input logic v);
        case (ch)
            0: arready = v;
            1: awready = v;
            2: wready  = v;
            3: rvalid  = v;
            default: bvalid = v;
        endcase
    endtask

    task automatic ready_slave(input int ch, input int lat);
        bit ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (sig(ch)) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            timeout_fail($sformatf("slave_ch%0d", ch));
            return;
        end
        repeat (lat) @(negedge clk);
        set_ready(ch, 1'b1);
        @(negedge clk);
        set_ready(ch, 1'b0);
    endtask

    task automatic resp_sink(input int hold);
        bit ok = 1'b0;
        int cyc = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (resp_valid) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            timeout_fail("resp_wait");
            return;
        end
        for (int i = 0; i < 1000; i++) begin
            resp_ready = (cyc >= hold);
            @(posedge clk);
            cyc++;
            if (resp_ready) break;
            @(negedge clk);
            if (!resp_valid) break;
        end
        @(negedge clk);
        resp_ready = 1'b0;
        chk("resp_len", 32'(cyc), 32'(hold + 1));
        chk("idle_after_resp", {31'b0, req_ready}, 32'h1);
    endtask

    task automatic issue_req(input bit wen, input bit ren, input logic [2:0] op,
                             input logic [31:0] addr, input logic [31:0] wd);
        bit ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        if (!ok) timeout_fail("req_ready_wait");
        req_valid = 1'b1;
        req_wen   = wen;
        req_ren   = ren;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
    endtask

    task automatic do_txn(input bit wen, input bit ren, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                          input logic [1:0] rrsp, input logic [1:0] brsp,
                          input int lat_a, input int lat_r, input int lat_w, input int lat_b,
                          input int hold);
        int unsigned a = addr % 4;
        int a0, aw0, w0, r0, b0;
        exp_addr  = addr - a;
        exp_wdata = m_wdata(op, wd);
        exp_wstrb = m_wstrb(op, a);
        if (!wen && !ren) begin
            exp_bus = 0; exp_rdata = '0; exp_err = 1'b0;
        end else if (m_mis(op, a)) begin
            exp_bus = 0; exp_rdata = '0; exp_err = 1'b1;
        end else if (wen) begin
            exp_bus = 2; exp_rdata = '0; exp_err = (brsp != 2'b00);
        end else begin
            exp_bus = 1; exp_rdata = m_load(op, a, rd); exp_err = (rrsp != 2'b00);
        end
        rdata = rd;
        rresp = rrsp;
        bresp = brsp;
        issue_req(wen, ren, op, addr, wd);
        a0 = ar_hs; aw0 = aw_hs; w0 = w_hs; r0 = r_hs; b0 = b_hs;
        txn_active = 1'b1;
        fork
            begin @(negedge clk); req_valid = 1'b0; end
            begin if (exp_bus == 1) ready_slave(0, lat_a); end
            begin if (exp_bus == 1) ready_slave(3, lat_r); end
            begin if (exp_bus == 2) ready_slave(1, lat_a); end
            begin if (exp_bus == 2) ready_slave(2, lat_w); end
            begin if (exp_bus == 2) ready_slave(4, lat_b); end
            resp_sink(hold);
        join
        txn_active = 1'b0;
        chk("ar_count", 32'(ar_hs - a0), (exp_bus == 1) ? 32'h1 : 32'h0);
        chk("r_count",  32'(r_hs - r0),  (exp_bus == 1) ? 32'h1 : 32'h0);
        chk("aw_count", 32'(aw_hs - aw0), (exp_bus == 2) ? 32'h1 : 32'h0);
        chk("w_count",  32'(w_hs - w0),  (exp_bus == 2) ? 32'h1 : 32'h0);
        chk("b_count",  32'(b_hs - b0),  (exp_bus == 2) ? 32'h1 : 32'h0);
        chk("final_rdata", last_rdata, exp_rdata);
        chk("final_err", {31'b0, last_err}, {31'b0, exp_err});
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_wen = 1'b0; req_ren = 1'b0; req_op = '0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;
        arready = 1'b0; rvalid = 1'b0; rresp = '0; rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_valids", {26'b0, arvalid, awvalid, wvalid, rready, bready, resp_valid}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'h0);
        chk("rst_araddr", araddr, 32'h0);
        chk("rst_awaddr", awaddr, 32'h0);
        chk("rst_wdata", wdata, 32'h0);
        chk("rst_wstrb", {24'b0, wstrb}, 32'h0);
        rst = 1'b0;

        // LB, data arrives 5 cycles into RD_DATA
        do_txn(1'b0, 1'b1, LB, 32'h80000003, 32'h0, 32'h80FF1234, 2'b00, 2'b00, 1, 5, 0, 0, 0);
        chk("lb_value", last_rdata, 32'hFFFFFF80);
        chk("lb_araddr", last_araddr, 32'h80000000);

        do_txn(1'b0, 1'b1, LHU, 32'h80000002, 32'h0, 32'hBEEF0000, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        chk("lhu_value", last_rdata, 32'h0000BEEF);

        // SB with awready one cycle ahead of wready
        do_txn(1'b1, 1'b0, 3'd0, 32'h80000001, 32'h000000AB, 32'h0, 2'b00, 2'b00, 0, 0, 1, 2, 0);
        chk("sb_wdata", last_wdata, 32'hABABABAB);
        chk("sb_wstrb", {24'b0, last_wstrb}, 32'h02);

        do_txn(1'b0, 1'b1, LW, 32'h80000002, 32'h0, 32'h11111111, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        chk("lw_mis_err", {31'b0, last_err}, 32'h1);

        // SW with slave error and a slow consumer
        do_txn(1'b1, 1'b0, 3'd2, 32'h80000004, 32'h12345678, 32'h0, 2'b00, 2'b10, 2, 0, 0, 1, 3);
        chk("sw_berr", {31'b0, last_err}, 32'h1);

        do_txn(1'b0, 1'b1, LH, 32'h80000000, 32'h0, 32'h00008001, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        chk("lh_value", last_rdata, 32'hFFFF8001);

        do_txn(1'b0, 1'b1, LBU, 32'h80000001, 32'h0, 32'h123456F0, 2'b00, 2'b00, 2, 1, 0, 0, 1);
        chk("lbu_value", last_rdata, 32'h00000056);

        do_txn(1'b1, 1'b0, 3'd1, 32'h80000002, 32'h1234CDEF, 32'h0, 2'b00, 2'b00, 3, 0, 0, 0, 0);
        chk("sh_wdata", last_wdata, 32'hCDEFCDEF);
        chk("sh_wstrb", {24'b0, last_wstrb}, 32'h0C);

        do_txn(1'b0, 1'b0, LW, 32'h80000008, 32'h0, 32'h0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        chk("nop_err", {31'b0, last_err}, 32'h0);

        do_txn(1'b0, 1'b1, LW, 32'h80000008, 32'h0, 32'hDEADBEEF, 2'b10, 2'b00, 0, 2, 0, 0, 0);
        chk("lw_rerr_value", last_rdata, 32'hDEADBEEF);
        chk("lw_rerr_err", {31'b0, last_err}, 32'h1);

        do_txn(1'b1, 1'b0, 3'd1, 32'h80000003, 32'h0000FFFF, 32'h0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        chk("sh_mis_err", {31'b0, last_err}, 32'h1);

        // Reset while waiting in RD_DATA with no rvalid coming
        exp_bus = 1; exp_addr = 32'h80000010; exp_rdata = '0; exp_err = 1'b0;
        issue_req(1'b0, 1'b1, LW, 32'h80000010, 32'h0);
        txn_active = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_test_arvalid", {31'b0, arvalid}, 32'h1);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        chk("rst_test_rready", {31'b0, rready}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_rready", {31'b0, rready}, 32'h0);
        chk("mid_rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("mid_rst_req_ready", {31'b0, req_ready}, 32'h1);
        chk("mid_rst_arvalid", {31'b0, arvalid}, 32'h0);
        txn_active = 1'b0;
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_no_resp", {31'b0, resp_valid}, 32'h0);
        end

        do_txn(1'b0, 1'b1, LW, 32'h8000000C, 32'h0, 32'hCAFEF00D, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        chk("lw_after_rst", last_rdata, 32'hCAFEF00D);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
